// File: rtl/fifo_ext.sv
// fifo_ext: parametrised circular-buffer FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and a selectable FWFT or registered read port.
// All state changes on the falling edge of CLK.
module fifo_ext #(
   parameter int unsigned B      = 8,
   parameter int unsigned W      = 5,
   parameter int unsigned AF_THR = 28,
   parameter int unsigned AE_THR = 4,
   parameter int unsigned FWFT   = 1
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         clr,
   input  logic         wr,
   input  logic         rd,
   input  logic [B-1:0] w_data,
   output logic [B-1:0] r_data,
   output logic         r_valid,
   output logic         empty,
   output logic         full,
   output logic         almost_empty,
   output logic         almost_full,
   output logic [W:0]   count,
   output logic         overflow,
   output logic         underflow
);

   localparam int unsigned D      = 2 ** W;
   localparam logic [W:0]  D_C    = (W + 1)'(D);
   localparam logic [W:0]  AF_C   = (W + 1)'(AF_THR);
   localparam logic [W:0]  AE_C   = (W + 1)'(AE_THR);

   logic [B-1:0] mem [D];

   logic [W-1:0] w_ptr;
   logic [W-1:0] r_ptr;
   logic [W:0]   count_reg;
   logic [W:0]   count_next;
   logic         empty_reg;
   logic         full_reg;
   logic         ae_reg;
   logic         af_reg;
   logic         ovf_reg;
   logic         udf_reg;
   logic         wr_acc;
   logic         rd_acc;

   // Accept decisions and next occupancy, all from registered state.
   // A write into a full FIFO is accepted only when a read frees the head
   // slot in the same cycle; the read then sees the old head word.
   always_comb begin
      wr_acc     = wr & (~full_reg | rd);
      rd_acc     = rd & ~empty_reg;
      count_next = count_reg + {{W{1'b0}}, wr_acc} - {{W{1'b0}}, rd_acc};
   end

   // Pointers, occupancy, status and sticky error flags.
   always_ff @(negedge CLK) begin
      if (RESET || clr) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         count_reg <= '0;
         empty_reg <= 1'b1;
         full_reg  <= 1'b0;
         ae_reg    <= 1'b1;
         af_reg    <= 1'b0;
         ovf_reg   <= 1'b0;
         udf_reg   <= 1'b0;
      end else begin
         if (wr_acc)
            w_ptr <= w_ptr + 1'b1;
         if (rd_acc)
            r_ptr <= r_ptr + 1'b1;
         count_reg <= count_next;
         empty_reg <= (count_next == '0);
         full_reg  <= (count_next == D_C);
         ae_reg    <= (count_next <= AE_C);
         af_reg    <= (count_next >= AF_C);
         if (wr && full_reg && !rd)
            ovf_reg <= 1'b1;
         if (rd && empty_reg)
            udf_reg <= 1'b1;
      end
   end

   // Storage: single write port, no reset so it maps onto RAM.
   always_ff @(negedge CLK) begin
      if (!RESET && !clr && wr_acc)
         mem[w_ptr] <= w_data;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is always presented; valid whenever something is stored.
         always_comb begin
            r_data  = mem[r_ptr];
            r_valid = ~empty_reg;
         end
      end else begin : g_reg
         logic [B-1:0] r_data_reg;
         logic         r_valid_reg;

         // Registered read port: loads the head on each accepted read and
         // flags valid for the following cycle only. When full, the head slot
         // is rewritten at this same edge; the non-blocking read keeps the
         // old word.
         always_ff @(negedge CLK) begin
            if (RESET || clr) begin
               r_data_reg  <= '0;
               r_valid_reg <= 1'b0;
            end else begin
               r_valid_reg <= rd_acc;
               if (rd_acc)
                  r_data_reg <= mem[r_ptr];
            end
         end

         // Drive the registered read outputs.
         always_comb begin
            r_data  = r_data_reg;
            r_valid = r_valid_reg;
         end
      end
   endgenerate

   // Drive status outputs from their registers.
   always_comb begin
      empty        = empty_reg;
      full         = full_reg;
      almost_empty = ae_reg;
      almost_full  = af_reg;
      count        = count_reg;
      overflow     = ovf_reg;
      underflow    = udf_reg;
   end

endmodule

// File: tb/tb_fifo_ext.sv
// tb_fifo_ext: drives one stimulus stream into an FWFT and a registered-read
// fifo_ext and checks both against a queue-based reference model.
module tb_fifo_ext;

   localparam int B  = 8;
   localparam int W  = 5;
   localparam int D  = 32;
   localparam int AF = 28;
   localparam int AE = 4;

   logic         CLK = 1'b0;
   logic         RESET = 1'b1;
   logic         clr = 1'b0;
   logic         wr = 1'b0;
   logic         rd = 1'b0;
   logic [B-1:0] w_data = '0;

   logic [B-1:0] r_data1, r_data0;
   logic         r_valid1, r_valid0;
   logic         empty1, empty0, full1, full0;
   logic         ae1, ae0, af1, af0;
   logic [W:0]   count1, count0;
   logic         ovf1, ovf0, udf1, udf0;

   int vectors = 0;
   int miscompares = 0;

   logic [B-1:0] q[$];
   logic         ovf_m = 1'b0;
   logic         udf_m = 1'b0;
   logic [B-1:0] last0 = '0;
   logic         rv0 = 1'b0;

   fifo_ext #(.B(B), .W(W), .AF_THR(AF), .AE_THR(AE), .FWFT(1)) dut1 (
      .CLK(CLK), .RESET(RESET), .clr(clr), .wr(wr), .rd(rd), .w_data(w_data),
      .r_data(r_data1), .r_valid(r_valid1), .empty(empty1), .full(full1),
      .almost_empty(ae1), .almost_full(af1), .count(count1),
      .overflow(ovf1), .underflow(udf1));

   fifo_ext #(.B(B), .W(W), .AF_THR(AF), .AE_THR(AE), .FWFT(0)) dut0 (
      .CLK(CLK), .RESET(RESET), .clr(clr), .wr(wr), .rd(rd), .w_data(w_data),
      .r_data(r_data0), .r_valid(r_valid0), .empty(empty0), .full(full0),
      .almost_empty(ae0), .almost_full(af0), .count(count0),
      .overflow(ovf0), .underflow(udf0));

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One falling-edge cycle with the given inputs; model update and checks.
   task automatic cycle(input logic i_rst, input logic i_clr, input logic i_wr,
                        input logic i_rd, input logic [B-1:0] d);
      logic fm, em, wa, ra;
      logic [B-1:0] e;
      int n;
      RESET = i_rst; clr = i_clr; wr = i_wr; rd = i_rd; w_data = d;
      if (i_rst || i_clr) begin
         q.delete();
         ovf_m = 1'b0; udf_m = 1'b0; last0 = '0; rv0 = 1'b0;
      end else begin
         fm = (q.size() == D);
         em = (q.size() == 0);
         wa = i_wr && (!fm || i_rd);
         ra = i_rd && !em;
         if (i_wr && fm && !i_rd) ovf_m = 1'b1;
         if (i_rd && em) udf_m = 1'b1;
         rv0 = ra;
         if (ra) begin
            e = q.pop_front();
            check("fwft_rdata", 32'(r_data1), 32'(e));
            last0 = e;
         end
         if (wa) q.push_back(d);
      end
      @(negedge CLK);
      #1;
      n = q.size();
      check("count",        32'(count1),   32'(n));
      check("empty",        32'(empty1),   32'(n == 0));
      check("full",         32'(full1),    32'(n == D));
      check("almost_empty", 32'(ae1),      32'(n <= AE));
      check("almost_full",  32'(af1),      32'(n >= AF));
      check("overflow",     32'(ovf1),     32'(ovf_m));
      check("underflow",    32'(udf1),     32'(udf_m));
      check("fwft_rvalid",  32'(r_valid1), 32'(n != 0));
      check("reg_count",    32'(count0),   32'(n));
      check("reg_empty",    32'(empty0),   32'(n == 0));
      check("reg_full",     32'(full0),    32'(n == D));
      check("reg_overflow", 32'(ovf0),     32'(ovf_m));
      check("reg_underflow",32'(udf0),     32'(udf_m));
      check("reg_rvalid",   32'(r_valid0), 32'(rv0));
      check("reg_rdata",    32'(r_data0),  32'(last0));
   endtask

   task automatic fill_overflow_drain_to_7(input logic [B-1:0] base);
      for (int i = 0; i < D; i++) cycle(0, 0, 1, 0, base + 8'(i));
      cycle(0, 0, 1, 0, 8'hEE);
      for (int i = 0; i < D - 7; i++) cycle(0, 0, 0, 1, 8'h00);
      check("pre_flush_count", 32'(count1), 32'd7);
      check("pre_flush_ovf",   32'(ovf1),   32'd1);
   endtask

   initial begin
      @(negedge CLK);
      #1;
      cycle(1, 0, 0, 0, 8'h00);
      cycle(1, 0, 1, 0, 8'h55);

      // Fill 0x01..0x20, then one write too many.
      for (int i = 1; i <= D; i++) cycle(0, 0, 1, 0, 8'(i));
      cycle(0, 0, 1, 0, 8'h99);
      check("ovf_count_32", 32'(count1), 32'd32);

      // Drain all, then one read too many.
      for (int i = 0; i <= D; i++) cycle(0, 0, 0, 1, 8'h00);
      check("udf_after_drain", 32'(udf1), 32'd1);

      // Pointer wrap.
      cycle(0, 1, 0, 0, 8'h00);
      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < 20; j++) cycle(0, 0, 1, 0, 8'(r * 20 + j + 64));
         for (int j = 0; j < 20; j++) cycle(0, 0, 0, 1, 8'h00);
         check("wrap_count_zero", 32'(count1), 32'd0);
      end

      // Simultaneous read/write mid, at full and at empty.
      for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 8'(i + 8'hA0));
      cycle(0, 0, 1, 1, 8'hC3);
      check("simul_mid_count", 32'(count1), 32'd10);
      for (int i = 0; i < 22; i++) cycle(0, 0, 1, 0, 8'(i + 8'hB0));
      cycle(0, 0, 1, 1, 8'h5A);
      check("simul_full_count", 32'(count1), 32'd32);
      check("simul_full_flag",  32'(full1),  32'd1);
      for (int i = 0; i < D; i++) cycle(0, 0, 0, 1, 8'h00);
      cycle(0, 0, 1, 1, 8'hAA);
      check("simul_empty_count", 32'(count1), 32'd1);
      check("simul_empty_udf",   32'(udf1),   32'd1);
      cycle(0, 0, 0, 1, 8'h00);

      // Registered read port sequence.
      cycle(0, 1, 0, 0, 8'h00);
      cycle(0, 0, 1, 0, 8'h11);
      cycle(0, 0, 1, 0, 8'h22);
      cycle(0, 0, 0, 1, 8'h00);
      check("reg_first_read", 32'(r_data0), 32'h11);
      cycle(0, 0, 0, 1, 8'h00);
      check("reg_second_read", 32'(r_data0), 32'h22);
      cycle(0, 0, 0, 0, 8'h00);
      cycle(0, 0, 0, 0, 8'h00);
      check("reg_hold", 32'(r_data0), 32'h22);

      // Flush with a write in the same cycle, then RESET together with clr.
      fill_overflow_drain_to_7(8'h30);
      cycle(0, 1, 1, 0, 8'hEE);
      check("clr_count", 32'(count1), 32'd0);
      check("clr_ovf",   32'(ovf1),   32'd0);
      fill_overflow_drain_to_7(8'h60);
      cycle(1, 1, 1, 0, 8'hEE);
      check("rst_clr_count", 32'(count1), 32'd0);
      cycle(0, 0, 1, 0, 8'h77);
      cycle(0, 0, 0, 1, 8'h00);
      check("post_reset_read", 32'(r_data0), 32'h77);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_ext.md
Name: fifo_ext

Overview:
- Parametrised successor to the team's circular-buffer FIFO, used between the UART and the BIP core, and between BIP peripherals.
- Adds:
  - occupancy count
  - programmable almost-full / almost-empty thresholds
  - sticky overflow / underflow error flags
  - synchronous flush
  - selectable read mode: first-word-fall-through or registered output
  - defined simultaneous read/write at empty and at full

Parameters:
- B, 8, data width in bits.
- W, 5, address width; depth D = 2**W words.
- AF_THR, 28, almost_full asserts when count >= AF_THR (legal range 1..D).
- AE_THR, 4, almost_empty asserts when count <= AE_THR (legal range 0..D-1).
- FWFT, 1:
  - 1 = r_data shows the head word combinationally.
  - 0 = r_data is a register loaded on each accepted read.

Ports:
- CLK, input, 1, clock; all state updates on the falling edge (codebase convention).
- RESET, input, 1, synchronous active-high reset.
- clr, input, 1, synchronous flush; empties the FIFO and clears error flags.
- wr, input, 1, write request.
- rd, input, 1, read request.
- w_data, input, B, write data.
- r_data, output, B, read data.
- r_valid, output, 1, r_data holds valid data (meaning depends on mode).
- empty, output, 1, FIFO empty.
- full, output, 1, FIFO full.
- almost_empty, output, 1, count <= AE_THR.
- almost_full, output, 1, count >= AF_THR.
- count, output, W+1, words stored, 0..D.
- overflow, output, 1, sticky: a write was attempted while full and not accepted.
- underflow, output, 1, sticky: a read was attempted while empty.

Behaviour:
- Reset (RESET=1 at a falling edge):
  - w_ptr=0, r_ptr=0, count=0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0, r_valid=0.
  - r_data register=0 (FWFT=0).
  - Memory contents are not cleared.
  - Reset mid-operation discards everything, including a write or read presented in the same cycle.
- clr:
  - Same effect as RESET, but lower priority than RESET.
  - Any wr/rd in the clr cycle is ignored.
- Accept rules, evaluated on registered state before the edge:
  - wr_acc = wr & (~full | rd).
  - rd_acc = rd & ~empty.
- Updates on an accepted write/read:
  - wr_acc: mem[w_ptr] <= w_data, w_ptr+1.
  - rd_acc: r_ptr+1.
  - Pointers wrap modulo D with no special handling.
  - count_next = count + wr_acc - rd_acc, computed in W+1 bits.
- Simultaneous wr & rd:
  - Not empty, not full: both accepted; count unchanged; flags unchanged.
  - Full: both accepted. The old head is read out (FWFT: sampled before the edge; registered mode: loaded at the same edge), then the slot is rewritten. count stays D and full stays 1.
  - Empty: write accepted, read rejected. count becomes 1 and underflow is set. In FWFT=0 the new word is NOT read out.
- Status flags:
  - Registered from count_next: empty = (count_next==0), full = (count_next==D).
  - almost_* follow the same rule.
  - All flags change on the same edge as count; no combinational paths from wr/rd to any flag.
- Errors:
  - overflow <= 1 when wr & full & ~rd.
  - underflow <= 1 when rd & empty.
  - Both hold until RESET or clr.
  - The FIFO state is untouched by the rejected operation.
- FWFT=1:
  - r_data = mem[r_ptr] combinationally; r_valid = ~empty.
  - First write to an empty FIFO: data visible and r_valid=1 after that edge (0 cycles extra latency).
- FWFT=0:
  - On rd_acc, r_data <= mem[r_ptr] at the same edge.
  - r_valid = 1 for exactly the cycle after each rd_acc; 0 otherwise.
  - r_data holds its last value when no read is accepted.
  - Read latency is 1 cycle.
- Memory: inferable as distributed or block RAM with a single write port; no read-during-write bypass beyond the full case above.

Test Plan:
- Reset, then write 0x01..0x20 (32 words, W=5) with no reads → count 1..32; almost_full first goes high at count=28; full=1 after the 32nd write; a 33rd wr sets overflow=1 with count still 32.
- Drain a full FIFO with 32 rd (FWFT=1) → r_data sequence 0x01..0x20; almost_empty rises at count=4; empty=1 after the last read; one extra rd sets underflow=1.
- Pointer wrap: repeat 5 times (write 20 words, read 20 words), checking data order → no loss or duplication across wrap; count returns to 0 each time.
- Simultaneous wr&rd:
  - at count=10: count stays 10.
  - at full: count stays 32; read value is the old head; the new word appears 32 reads later.
  - at empty with w_data=0xAA: count=1, underflow=1, next read returns 0xAA.
- FWFT=0 build: write 0x11, 0x22, then assert rd for two cycles → r_valid high on the two following cycles with r_data 0x11 then 0x22; r_data holds 0x22 afterwards.
- clr with count=7 and overflow=1, with wr asserted the same cycle → count=0, empty=1, overflow=0, write ignored; RESET asserted together with clr behaves identically.
